// File: rtl/scic_gpio_port_if.sv
// Select/acknowledge register bus used by the SCIC core to reach the GPIO port.
// The master drives the request; the slave returns one-cycle ack and read data.
interface scic_gpio_port_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic              sel;
    logic              we;
    logic [1:0]        addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (
        output sel, we, addr, wdata,
        input  rdata, ack
    );

    modport slave (
        input  sel, we, addr, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/scic_gpio_port.sv
// Register-mapped switch/LED port: synchronised, debounced switches with sticky
// change flags and optional interrupt, plus a writable LED register.
module scic_gpio_port #(
    parameter int unsigned N_SW            = 4,
    parameter int unsigned N_LED           = 4,
    parameter int unsigned DATA_W          = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_SW-1:0]    switches,
    output logic [N_LED-1:0]   LEDs,
    output logic               irq,
    scic_gpio_port_if.slave    bus
);
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (N_SW > DATA_W || N_LED > DATA_W || N_SW == 0 || N_LED == 0 ||
        DEBOUNCE_CYCLES == 0) begin : g_bad_size
        $error("scic_gpio_port: illegal sizing parameters");
    end

    logic [N_SW-1:0]   sync1_q, sync_q;
    logic [N_SW-1:0]   stable_q, stable_d;
    logic [N_SW-1:0]   flags_q, flags_d, flag_set, w1c;
    logic [CNT_W-1:0]  cnt_q [N_SW];
    logic [CNT_W-1:0]  cnt_d [N_SW];
    logic [1:0]        ctrl_q, ctrl_d;
    logic [N_LED-1:0]  led_q, led_d;
    logic [DATA_W-1:0] rdata_q, rd_val;
    logic              ack_q, irq_q;
    logic              wr_en, rd_en, dbg_toggle;
    logic              unused_wdata;

    assign unused_wdata = ^bus.wdata;

    always_comb begin
        wr_en  = bus.sel & bus.we;
        rd_en  = bus.sel & ~bus.we;
        led_d  = led_q;
        ctrl_d = ctrl_q;
        w1c    = '0;
        if (wr_en) begin
            case (bus.addr)
                2'd1:    led_d  = bus.wdata[N_LED-1:0];
                2'd2:    w1c    = bus.wdata[N_SW-1:0];
                2'd3:    ctrl_d = bus.wdata[1:0];
                default: ;
            endcase
        end
        case (bus.addr)
            2'd0:    rd_val = DATA_W'(stable_q);
            2'd1:    rd_val = DATA_W'(led_q);
            2'd2:    rd_val = DATA_W'(flags_q);
            default: rd_val = DATA_W'(ctrl_q);
        endcase
        dbg_toggle = ctrl_d[0] != ctrl_q[0];

        stable_d = stable_q;
        flag_set = '0;
        for (int i = 0; i < int'(N_SW); i++) begin
            cnt_d[i] = cnt_q[i];
            if (!ctrl_q[0]) begin
                cnt_d[i] = '0;
                if (sync_q[i] != stable_q[i]) begin
                    stable_d[i] = sync_q[i];
                    flag_set[i] = 1'b1;
                end
            end else if (sync_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync_q[i];
                flag_set[i] = 1'b1;
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
            // Switching debounce mode restarts every pending count.
            if (dbg_toggle) cnt_d[i] = '0;
        end
        // A flag being set in the same cycle as its W1C survives.
        flags_d = (flags_q & ~w1c) | flag_set;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync_q   <= '0;
            stable_q <= '0;
            flags_q  <= '0;
            cnt_q    <= '{default: '0};
            ctrl_q   <= 2'b01;
            led_q    <= '0;
            rdata_q  <= '0;
            ack_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            sync1_q  <= switches;
            sync_q   <= sync1_q;
            stable_q <= stable_d;
            flags_q  <= flags_d;
            cnt_q    <= cnt_d;
            ctrl_q   <= ctrl_d;
            led_q    <= led_d;
            ack_q    <= bus.sel;
            if (rd_en) rdata_q <= rd_val;
            irq_q    <= ctrl_q[1] & (|flags_q);
        end
    end

    assign LEDs      = led_q;
    assign irq       = irq_q;
    assign bus.rdata = rdata_q;
    assign bus.ack   = ack_q;
endmodule
